// File: rtl/rca_pkg.sv
// Shared types and defaults for the multiword ripple-carry sequencer.
package rca_pkg;

    localparam int unsigned WordW  = 16;
    localparam int unsigned SliceW = 4;
    // Stage count of the external pipelined 4-bit adder.
    localparam int unsigned AddLat = 4;

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

    function automatic int unsigned n_slices(int unsigned word_w, int unsigned slice_w);
        return word_w / slice_w;
    endfunction

endpackage

// File: rtl/rca_multiword_sequencer_if.sv
// Operand and result handshake bundle for the multiword sequencer.
interface rca_multiword_sequencer_if #(
    parameter int unsigned WORD_W = 16
) ();

    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] op_a;
    logic [WORD_W-1:0] op_b;
    logic              op_cin;
    logic              out_valid;
    logic              out_ready;
    logic [WORD_W-1:0] result;
    logic              result_cout;

    modport master (
        output in_valid, op_a, op_b, op_cin, out_ready,
        input  in_ready, out_valid, result, result_cout
    );

    modport slave (
        input  in_valid, op_a, op_b, op_cin, out_ready,
        output in_ready, out_valid, result, result_cout
    );

endinterface

// File: rtl/rca_multiword_sequencer.sv
// Splits a WORD_W addition into SLICE_W slices, runs them LSB-first through an
// external pipelined adder and reassembles the sum.
module rca_multiword_sequencer
    import rca_pkg::*;
#(
    parameter int unsigned WORD_W  = WordW,
    parameter int unsigned SLICE_W = SliceW,
    parameter int unsigned ADD_LAT = AddLat
) (
    input  logic                          clk,
    input  logic                          rst,
    rca_multiword_sequencer_if.slave      bus,
    output logic [SLICE_W-1:0]            add_a,
    output logic [SLICE_W-1:0]            add_b,
    output logic                          add_cin,
    input  logic [SLICE_W-1:0]            add_sum,
    input  logic                          add_cout
);

    localparam int unsigned NSlices = n_slices(WORD_W, SLICE_W);
    localparam int unsigned IdxW    = (NSlices > 1) ? $clog2(NSlices) : 1;
    localparam int unsigned CntW    = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;

    state_e              state_q, state_d;
    logic [WORD_W-1:0]   a_q, a_d, b_q, b_d, res_q, res_d;
    logic                carry_q, carry_d, cout_q, cout_d;
    logic [IdxW-1:0]     idx_q, idx_d;
    logic [CntW-1:0]     wait_cnt_q, wait_cnt_d;
    logic                in_ready_q, in_ready_d, out_valid_q, out_valid_d;
    logic [SLICE_W-1:0]  add_a_q, add_a_d, add_b_q, add_b_d;
    logic                add_cin_q, add_cin_d;

    // Adder inputs are registered, so they are loaded on the edge entering ISSUE
    // and simply held through WAIT.
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        res_d       = res_q;
        carry_d     = carry_q;
        cout_d      = cout_q;
        idx_d       = idx_q;
        wait_cnt_d  = wait_cnt_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        add_a_d     = add_a_q;
        add_b_d     = add_b_q;
        add_cin_d   = add_cin_q;
        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    a_d        = bus.op_a;
                    b_d        = bus.op_b;
                    carry_d    = bus.op_cin;
                    idx_d      = '0;
                    add_a_d    = bus.op_a[SLICE_W-1:0];
                    add_b_d    = bus.op_b[SLICE_W-1:0];
                    add_cin_d  = bus.op_cin;
                    in_ready_d = 1'b0;
                    state_d    = StIssue;
                end
            end
            StIssue: begin
                wait_cnt_d = CntW'(ADD_LAT - 1);
                state_d    = StWait;
            end
            StWait: begin
                if (wait_cnt_q != '0) begin
                    wait_cnt_d = wait_cnt_q - CntW'(1);
                end else begin
                    res_d[idx_q*SLICE_W +: SLICE_W] = add_sum;
                    carry_d = add_cout;
                    if (idx_q == IdxW'(NSlices - 1)) begin
                        cout_d      = add_cout;
                        out_valid_d = 1'b1;
                        state_d     = StDone;
                    end else begin
                        idx_d     = idx_q + IdxW'(1);
                        add_a_d   = a_q[idx_d*SLICE_W +: SLICE_W];
                        add_b_d   = b_q[idx_d*SLICE_W +: SLICE_W];
                        add_cin_d = add_cout;
                        state_d   = StIssue;
                    end
                end
            end
            StDone: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            carry_q     <= 1'b0;
            cout_q      <= 1'b0;
            idx_q       <= '0;
            wait_cnt_q  <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            add_a_q     <= '0;
            add_b_q     <= '0;
            add_cin_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            res_q       <= res_d;
            carry_q     <= carry_d;
            cout_q      <= cout_d;
            idx_q       <= idx_d;
            wait_cnt_q  <= wait_cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            add_a_q     <= add_a_d;
            add_b_q     <= add_b_d;
            add_cin_q   <= add_cin_d;
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.result      = res_q;
    assign bus.result_cout = cout_q;
    assign add_a           = add_a_q;
    assign add_b           = add_b_q;
    assign add_cin         = add_cin_q;

endmodule
